timer_regs: RTL and testbench
=============================

Name: timer_regs

Overview:
- APB register bank and 64-bit count register for the timer IP.
- Drives the counter-control configuration: timer_en, div_en, div_val and halt_req.
- Consumes the count enable and the halt acknowledge that the counter-control block returns.
- Holds the 64-bit counter, the 64-bit compare value and the interrupt logic, and drives the interrupt output.

Parameters:
- ADDR_W, 12, APB address width; only paddr[4:2] is decoded, paddr[1:0] ignored.
- CNT_RST, 64'h0, counter reset value and the value it is cleared to.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- psel  in  1  APB select
- penable  in  1  APB access phase
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_W  byte address
- pwdata  in  32  write data
- pstrb  in  4  write byte strobes
- prdata  out  32  read data
- pready  out  1  transfer complete
- pslverr  out  1  transfer error
- cnt_en  in  1  increment the counter this cycle
- halt_ack  in  1  counter-control confirms it is halted
- timer_en  out  1  TCR[0]
- div_en  out  1  TCR[1]
- div_val  out  4  TCR[11:8]
- halt_req  out  1  THCSR[0]
- tim_int  out  1  interrupt, level, active-high

Behaviour:
- Reset (asynchronous):
  - All registers take their reset values; prdata = 0, pready = 0, pslverr = 0, tim_int = 0.
  - Reset in mid-transfer abandons the transfer.
- APB timing:
  - Exactly one wait state. In the first access-phase cycle (psel & penable & !pready), pready = 0.
  - Next cycle: pready = 1 for exactly one cycle, together with registered prdata and pslverr.
  - The write commits on the edge ending the pready cycle, under pstrb byte lanes.
  - psel dropped mid-access aborts with no side effect.
  - Idle: prdata = 0 and pslverr = 0.
- Register map (word offset):
  - 0x00 TCR: [0] timer_en, [1] div_en, [11:8] div_val; reset 0x0000_0100. All other bits read 0.
  - 0x04 TDR0: counter [31:0], RW.
  - 0x08 TDR1: counter [63:32], RW.
  - 0x0C TCMP0: compare [31:0], RW, reset 0xFFFF_FFFF.
  - 0x10 TCMP1: compare [63:32], RW, reset 0xFFFF_FFFF.
  - 0x14 TIER: [0] int_en, RW, reset 0.
  - 0x18 TISR: [0] int_st, write-1-to-clear, reset 0.
  - 0x1C THCSR: [0] halt_req RW, [1] halt_ack RO (live input value); reset 0.
- Unmapped offsets: read 0, writes ignored, pslverr = 0.
- TCR write errors: a TCR write gives pslverr = 1 and leaves TCR unchanged if either:
  - the written div_val > 8; or
  - timer_en is currently 1 and the write changes div_en or div_val.
  - A TCR write that only changes timer_en is always accepted.
- Counter increment:
  - When cnt_en = 1, the counter adds 1 modulo 2^64.
  - Carry from bit 31 into bit 32 happens in the same cycle; wrap from all-ones goes to 0.
- Timer disable: on the cycle TCR timer_en goes 1→0, the counter loads CNT_RST. This takes priority over cnt_en.
- Counter write vs increment: a software write to TDR0 or TDR1 in the same cycle as cnt_en wins for the written bytes. Unwritten bytes of that word keep their old value (no increment applied that cycle).
- Interrupt:
  - int_st sets on any cycle where counter == compare, for all 64 bits, registered.
  - A set and a W1C in the same cycle: set wins.
  - tim_int = int_en & int_st, registered with zero added latency beyond int_st.
- Halt:
  - halt_req is driven directly from THCSR[0].
  - While halted, cnt_en is 0 upstream; this block adds no gating.

Test Plan:
- Reset, then read every offset → TCR = 0x100, TCMP0/1 = 0xFFFF_FFFF, all others 0; pready is high only on the 2nd access cycle.
- Write TDR0 = 0xFFFF_FFFF, TDR1 = 0; hold cnt_en high 2 cycles → TDR1 = 1, TDR0 = 1. Set the counter to all-ones, pulse cnt_en → counter = 0.
- TCR = 0x0000_0003 with div_val = 1, then write div_val = 3 while timer_en = 1 → pslverr = 1, TCR reads 0x103. Write div_val = 9 with timer_en = 0 → pslverr = 1.
- TCMP = 5, TIER = 1, counter = 0, cnt_en held high → tim_int rises one cycle after the counter reads 5. Write TISR = 1 in the same cycle counter == compare → int_st stays 1.
- Write THCSR = 1 → halt_req = 1. Drive halt_ack = 1 → THCSR reads 0x3. Write 0 → halt_req = 0.
- Counter at 0x1234, then write TCR timer_en = 0 → counter reads 0. A TDR0 write coinciding with cnt_en → the written value is kept, with no +1.

Source files
------------

// File: rtl/timer_regs.sv
// Timer register bank: APB control/status registers, 64-bit count, 64-bit compare and the interrupt.
// Every APB access takes one wait state; a TCR write that would retune a running timer is refused with pslverr.
module timer_regs #(
  parameter int          ADDR_W  = 12,
  parameter logic [63:0] CNT_RST = 64'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  input  logic [3:0]        pstrb,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic              cnt_en,
  input  logic              halt_ack,
  output logic              timer_en,
  output logic              div_en,
  output logic [3:0]        div_val,
  output logic              halt_req,
  output logic              tim_int
);

  localparam logic [2:0] OFS_TCR   = 3'd0;
  localparam logic [2:0] OFS_TDR0  = 3'd1;
  localparam logic [2:0] OFS_TDR1  = 3'd2;
  localparam logic [2:0] OFS_TCMP0 = 3'd3;
  localparam logic [2:0] OFS_TCMP1 = 3'd4;
  localparam logic [2:0] OFS_TIER  = 3'd5;
  localparam logic [2:0] OFS_TISR  = 3'd6;
  localparam logic [2:0] OFS_THCSR = 3'd7;

  logic [2:0]  ofs;
  logic        access_wait;
  logic        commit;
  logic [31:0] wmask;
  logic [31:0] rd_mux;
  logic [63:0] cnt;
  logic [63:0] cmp;
  logic        int_en;
  logic        int_st;
  logic        new_en;
  logic        new_div_en;
  logic [3:0]  new_div_val;
  logic        tcr_err;
  logic        we_tcr;
  logic        we_tdr0;
  logic        we_tdr1;
  logic        we_tcmp0;
  logic        we_tcmp1;
  logic        we_tier;
  logic        we_tisr;
  logic        we_thcsr;
  logic        unused_paddr;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [31:0] mask);
    return (old & ~mask) | (data & mask);
  endfunction

  assign ofs          = paddr[4:2];
  assign unused_paddr = ^{paddr[ADDR_W-1:5], paddr[1:0]};
  assign wmask        = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};

  // First access cycle samples read data / error; the following pready cycle commits writes.
  assign access_wait = psel & penable & ~pready;
  assign commit      = psel & penable & pready & pwrite;

  assign new_en      = pstrb[0] ? pwdata[0]    : timer_en;
  assign new_div_en  = pstrb[0] ? pwdata[1]    : div_en;
  assign new_div_val = pstrb[1] ? pwdata[11:8] : div_val;
  assign tcr_err     = (new_div_val > 4'd8) ||
                       (timer_en && ((new_div_en != div_en) || (new_div_val != div_val)));

  // pslverr holds the error verdict for this very transfer during the commit cycle.
  assign we_tcr   = commit && (ofs == OFS_TCR) && !pslverr;
  assign we_tdr0  = commit && (ofs == OFS_TDR0);
  assign we_tdr1  = commit && (ofs == OFS_TDR1);
  assign we_tcmp0 = commit && (ofs == OFS_TCMP0);
  assign we_tcmp1 = commit && (ofs == OFS_TCMP1);
  assign we_tier  = commit && (ofs == OFS_TIER);
  assign we_tisr  = commit && (ofs == OFS_TISR);
  assign we_thcsr = commit && (ofs == OFS_THCSR);

  always_comb begin
    rd_mux = 32'h0;
    case (ofs)
      OFS_TCR:   rd_mux = {20'h0, div_val, 6'h0, div_en, timer_en};
      OFS_TDR0:  rd_mux = cnt[31:0];
      OFS_TDR1:  rd_mux = cnt[63:32];
      OFS_TCMP0: rd_mux = cmp[31:0];
      OFS_TCMP1: rd_mux = cmp[63:32];
      OFS_TIER:  rd_mux = {31'h0, int_en};
      OFS_TISR:  rd_mux = {31'h0, int_st};
      OFS_THCSR: rd_mux = {30'h0, halt_ack, halt_req};
      default:   rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pready  <= 1'b0;
      prdata  <= 32'h0;
      pslverr <= 1'b0;
    end else begin
      pready  <= access_wait;
      prdata  <= (access_wait && !pwrite) ? rd_mux : 32'h0;
      pslverr <= access_wait && pwrite && (ofs == OFS_TCR) && tcr_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_en <= 1'b0;
      div_en   <= 1'b0;
      div_val  <= 4'd1;
      int_en   <= 1'b0;
      halt_req <= 1'b0;
      cmp      <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      if (we_tcr) begin
        timer_en <= new_en;
        div_en   <= new_div_en;
        div_val  <= new_div_val;
      end
      if (we_tcmp0) cmp[31:0]  <= merge(cmp[31:0], pwdata, wmask);
      if (we_tcmp1) cmp[63:32] <= merge(cmp[63:32], pwdata, wmask);
      if (we_tier && pstrb[0])  int_en   <= pwdata[0];
      if (we_thcsr && pstrb[0]) halt_req <= pwdata[0];
    end
  end

  // Disabling the timer clears the count; a software write suppresses that cycle's increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= CNT_RST;
    end else if (we_tcr && timer_en && !new_en) begin
      cnt <= CNT_RST;
    end else if (we_tdr0) begin
      cnt[31:0] <= merge(cnt[31:0], pwdata, wmask);
    end else if (we_tdr1) begin
      cnt[63:32] <= merge(cnt[63:32], pwdata, wmask);
    end else if (cnt_en) begin
      cnt <= cnt + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_st <= 1'b0;
    end else if (cnt == cmp) begin
      int_st <= 1'b1;
    end else if (we_tisr && pstrb[0] && pwdata[0]) begin
      int_st <= 1'b0;
    end
  end

  assign tim_int = int_en & int_st;

endmodule

// File: tb/tb_timer_regs.sv
// Bench for timer_regs: directed steps then random APB/count traffic checked against a register-level model.
module tb_timer_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        cnt_en, halt_ack;
  logic        timer_en, div_en, halt_req, tim_int;
  logic [3:0]  div_val;

  always #5 clk = ~clk;

  timer_regs #(.ADDR_W(12), .CNT_RST(64'h0)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .cnt_en(cnt_en), .halt_ack(halt_ack), .timer_en(timer_en),
    .div_en(div_en), .div_val(div_val), .halt_req(halt_req), .tim_int(tim_int)
  );

  int checks = 0;
  int errors = 0;

  // Register-level reference model
  logic [63:0] m_cnt, m_cmp;
  logic        m_ten, m_den, m_ier, m_isr, m_hreq, m_hack;
  logic [3:0]  m_dv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a[4:2])
      3'd0:    return {20'h0, m_dv, 6'h0, m_den, m_ten};
      3'd1:    return m_cnt[31:0];
      3'd2:    return m_cnt[63:32];
      3'd3:    return m_cmp[31:0];
      3'd4:    return m_cmp[63:32];
      3'd5:    return {31'h0, m_ier};
      3'd6:    return {31'h0, m_isr};
      default: return {30'h0, m_hack, m_hreq};
    endcase
  endfunction

  // n consecutive increments: the interrupt latches if the compare value is among the visited counts.
  task automatic model_run(input int n);
    logic [63:0] d;
    d = m_cmp - m_cnt;
    if (n > 0 && d != 64'h0 && d <= 64'(n)) m_isr = 1'b1;
    m_cnt = m_cnt + 64'(n);
  endtask

  task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic err);
    logic [31:0] m, nv;
    m   = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    nv  = (model_read(a) & ~m) | (d & m);
    err = 1'b0;
    case (a[4:2])
      3'd0: begin
        err = (nv[11:8] > 4'd8) || (m_ten && (nv[1] != m_den || nv[11:8] != m_dv));
        if (!err) begin
          if (m_ten && !nv[0]) m_cnt = 64'h0;
          m_ten = nv[0];
          m_den = nv[1];
          m_dv  = nv[11:8];
        end
      end
      3'd1: m_cnt[31:0]  = nv;
      3'd2: m_cnt[63:32] = nv;
      3'd3: m_cmp[31:0]  = nv;
      3'd4: m_cmp[63:32] = nv;
      3'd5: m_ier  = nv[0];
      3'd6: if (s[0] && d[0]) m_isr = 1'b0;
      default: m_hreq = nv[0];
    endcase
    if (m_cnt == m_cmp) m_isr = 1'b1;
  endtask

  task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic ce,
                     output logic [31:0] rd, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s; cnt_en = ce;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk("pready_wait", pready, 1'b0);
    @(negedge clk);
    chk("pready_done", pready, 1'b1);
    rd  = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; cnt_en = 1'b0;
    @(negedge clk);
    chk("idle_pready", pready, 1'b0);
    chk("idle_prdata", prdata, 32'h0);
  endtask

  task automatic w(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                   output logic err);
    logic [31:0] rd;
    logic        eerr;
    model_write(a, d, s, eerr);
    apb(1'b1, a, d, s, 1'b0, rd, err);
    chk($sformatf("wr_err@%0h", a), err, eerr);
  endtask

  task automatic r(input logic [11:0] a, output logic [31:0] rd);
    logic err;
    apb(1'b0, a, 32'h0, 4'h0, 1'b0, rd, err);
    chk($sformatf("rd@%0h", a), rd, model_read(a));
    chk("rd_err", err, 1'b0);
  endtask

  task automatic run_cnt(input int n);
    @(posedge clk); #1;
    cnt_en = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    cnt_en = 1'b0;
    model_run(n);
  endtask

  task automatic chk_outs();
    @(posedge clk);
    @(negedge clk);
    chk("timer_en", timer_en, m_ten);
    chk("div_en", div_en, m_den);
    chk("div_val", div_val, m_dv);
    chk("halt_req", halt_req, m_hreq);
    chk("tim_int", tim_int, m_ier & m_isr);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] rst_tab [8];
    logic [11:0] a;
    logic [31:0] d;

    rst_tab = '{32'h100, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
    rst_n = 1'b1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0;
    cnt_en = 0; halt_ack = 0;
    m_cnt = 64'h0; m_cmp = '1; m_ten = 0; m_den = 0; m_dv = 4'd1;
    m_ier = 0; m_isr = 0; m_hreq = 0; m_hack = 0;

    #3 rst_n = 1'b0;
    #2;
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pready", pready, 1'b0);
    chk("rst_pslverr", pslverr, 1'b0);
    chk("rst_tim_int", tim_int, 1'b0);
    chk("rst_div_val", div_val, 4'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values of every offset
    for (int i = 0; i < 8; i++) begin
      apb(1'b0, 12'(i * 4), 32'h0, 4'h0, 1'b0, rd, er);
      chk($sformatf("rst_reg%0d", i), rd, rst_tab[i]);
    end
    chk_outs();

    // psel dropped during the pready cycle: write to TIER must not land
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = 12'h014; pwdata = 32'h1; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1 psel = 0; penable = 0; pwrite = 0;
    @(posedge clk); #1;
    r(12'h014, rd);

    // Carry from the low word and wrap from all-ones
    w(12'h004, 32'hFFFF_FFFF, 4'hF, er);
    w(12'h008, 32'h0, 4'hF, er);
    run_cnt(2);
    r(12'h008, rd); chk("carry_hi", rd, 32'h1);
    r(12'h004, rd); chk("carry_lo", rd, 32'h1);
    w(12'h004, 32'hFFFF_FFFF, 4'hF, er);
    w(12'h008, 32'hFFFF_FFFF, 4'hF, er);
    run_cnt(1);
    r(12'h004, rd); chk("wrap_lo", rd, 32'h0);
    r(12'h008, rd); chk("wrap_hi", rd, 32'h0);
    r(12'h018, rd);
    w(12'h018, 32'h1, 4'hF, er);
    r(12'h018, rd);

    // TCR write protection
    w(12'h000, 32'h0000_0103, 4'hF, er);
    chk_outs();
    w(12'h000, 32'h0000_0303, 4'hF, er); chk("tcr_busy_err", er, 1'b1);
    r(12'h000, rd); chk("tcr_kept", rd, 32'h103);
    w(12'h004, 32'h1234, 4'hF, er);
    w(12'h000, 32'h0000_0102, 4'hF, er); chk("tcr_en_only", er, 1'b0);
    r(12'h004, rd); chk("disable_clears", rd, 32'h0);
    w(12'h000, 32'h0000_0900, 4'hF, er); chk("tcr_dv9_err", er, 1'b1);
    r(12'h000, rd);

    // Interrupt rises the cycle after the count sits on the compare value
    w(12'h010, 32'h0, 4'hF, er);
    w(12'h00C, 32'h5, 4'hF, er);
    w(12'h014, 32'h1, 4'hF, er);
    w(12'h004, 32'h0, 4'hF, er);
    w(12'h018, 32'h1, 4'hF, er);
    @(posedge clk); #1 cnt_en = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("tim_int_after_%0d", k), tim_int, 64'(k >= 6));
    end
    @(posedge clk); #1 cnt_en = 1'b0;
    model_run(9);
    r(12'h018, rd);
    w(12'h004, 32'h5, 4'hF, er);
    w(12'h018, 32'h1, 4'hF, er);
    r(12'h018, rd); chk("set_beats_w1c", rd, 32'h1);
    chk_outs();
    w(12'h004, 32'h10, 4'hF, er);
    w(12'h018, 32'h1, 4'hF, er);
    r(12'h018, rd);
    chk_outs();

    // Halt handshake
    w(12'h01C, 32'h1, 4'hF, er);
    chk_outs();
    halt_ack = 1'b1; m_hack = 1'b1;
    r(12'h01C, rd); chk("thcsr_ack", rd, 32'h3);
    w(12'h01C, 32'h0, 4'hF, er);
    chk_outs();
    halt_ack = 1'b0; m_hack = 1'b0;

    // Software write wins over a coincident increment
    w(12'h004, 32'h0, 4'hF, er);
    model_run(2);
    model_write(12'h004, 32'h0000_ABCD, 4'hF, er);
    apb(1'b1, 12'h004, 32'h0000_ABCD, 4'hF, 1'b1, rd, er);
    r(12'h004, rd); chk("wr_beats_inc", rd, 32'h0000_ABCD);
    model_run(2);
    model_write(12'h004, 32'h1234_0000, 4'b1100, er);
    apb(1'b1, 12'h004, 32'h1234_0000, 4'b1100, 1'b1, rd, er);
    r(12'h004, rd); chk("partial_wr_no_inc", rd, 32'h1234_ABCF);

    // Random traffic against the model
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0: run_cnt(int'($urandom_range(0, 12)));
        1: begin
          a = 12'($urandom);
          d = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
          if ($urandom_range(0, 3) == 0) d = d << 8;
          w(a, d, 4'($urandom), er);
        end
        2: r(12'($urandom), rd);
        default: begin
          halt_ack = 1'($urandom_range(0, 1));
          m_hack   = halt_ack;
          chk_outs();
        end
      endcase
    end
    chk_outs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
